// File: rtl/field_color_pkg.sv
// +--------------------------------------------------------------------------+
// | field_color_pkg : pixel classes and default playfield palettes.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package field_color_pkg;

  typedef enum logic [1:0] {
    CLS_BG_A = 2'd0,
    CLS_BG_B = 2'd1,
    CLS_LINE = 2'd2,
    CLS_FG   = 2'd3
  } pix_class_t;

  // Colours are {R,G,B} at 10 bits per channel; the top rescales to CW.
  localparam logic [29:0] c_black         = 30'h0;
  localparam logic [29:0] c_white         = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [29:0] c_court_orange  = {10'h3FF, 10'h200, 10'h000};
  localparam logic [29:0] c_court_dark    = {10'h300, 10'h180, 10'h000};
  localparam logic [29:0] c_field_light   = {10'h100, 10'h300, 10'h100};
  localparam logic [29:0] c_field_dark    = {10'h080, 10'h200, 10'h080};
  localparam logic [29:0] c_hall_tan      = {10'h340, 10'h2C0, 10'h1C0};
  localparam logic [29:0] c_hall_brown    = {10'h200, 10'h100, 10'h040};
  localparam logic [29:0] c_grey_light    = {10'h2A0, 10'h2A0, 10'h2A0};
  localparam logic [29:0] c_grey_dark     = {10'h120, 10'h120, 10'h120};

  function automatic logic [29:0] pal_default10(input int unsigned mode_idx, input logic [1:0] cls);
    logic [29:0] c;
    c = c_white;
    case (mode_idx)
      1: c = (cls == 2'd0) ? c_field_light : (cls == 2'd1) ? c_field_dark : c_white;
      2: c = (cls == 2'd2) ? c_hall_brown : (cls == 2'd3) ? c_white : c_hall_tan;
      3: c = (cls == 2'd0) ? c_grey_light : (cls == 2'd1) ? c_grey_dark : c_white;
      default: c = (cls == 2'd0) ? c_court_orange : (cls == 2'd1) ? c_court_dark : c_white;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/field_color_pipe_tile_counter.sv
// +--------------------------------------------------------------------------+
// | field_tile_counter : column/row tile counters with tile parity.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module field_tile_counter #(
  parameter  int TILE_W = 80,
  parameter  int TILE_H = 60,
  localparam int CXW    = $clog2(TILE_W),
  localparam int CYW    = $clog2(TILE_H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_valid,
  input  logic           line_start,
  input  logic           frame_start,
  output logic [CXW-1:0] col_cnt,
  output logic [CYW-1:0] row_cnt,
  output logic           col_par,
  output logic           row_par
);

  logic [CXW-1:0] r_col_cnt;
  logic [CYW-1:0] r_row_cnt;
  logic           r_col_par;
  logic           r_row_par;
  logic           r_first_line;

  // The first line_start of a frame opens row 0 rather than advancing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_col_par    <= 1'b0;
      r_row_par    <= 1'b0;
      r_first_line <= 1'b1;
    end else if (frame_start) begin
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_col_par    <= 1'b0;
      r_row_par    <= 1'b0;
      r_first_line <= !line_start;
    end else if (line_start) begin
      r_col_cnt <= '0;
      r_col_par <= 1'b0;
      if (r_first_line) begin
        r_first_line <= 1'b0;
      end else if (r_row_cnt == CYW'(TILE_H - 1)) begin
        r_row_cnt <= '0;
        r_row_par <= !r_row_par;
      end else begin
        r_row_cnt <= r_row_cnt + CYW'(1);
      end
    end else if (pix_valid) begin
      if (r_col_cnt == CXW'(TILE_W - 1)) begin
        r_col_cnt <= '0;
        r_col_par <= !r_col_par;
      end else begin
        r_col_cnt <= r_col_cnt + CXW'(1);
      end
    end
  end

  assign col_cnt = r_col_cnt;
  assign row_cnt = r_row_cnt;
  assign col_par = r_col_par;
  assign row_par = r_row_par;

endmodule

`default_nettype wire

// File: rtl/field_color_pipe.sv
// +--------------------------------------------------------------------------+
// | field_color_pipe : 2-stage playfield pixel colouriser with palette RAM.  |
// | Optional FIELD_FADE_EN: per-frame fade-in after each mode change. Rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module field_color_pipe
  import field_color_pkg::*;
#(
  parameter  int CW        = 10,
  parameter  int XW        = 10,
  parameter  int YW        = 10,
  parameter  int TILE_W    = 80,
  parameter  int TILE_H    = 60,
  parameter  int NUM_MODES = 4,
  localparam int MODE_W    = $clog2(NUM_MODES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid,
  input  logic                line_start,
  input  logic                frame_start,
  input  logic [XW-1:0]       x,
  input  logic [YW-1:0]       y,
  input  logic                px_fg,
  input  logic [MODE_W-1:0]   mode,
  input  logic                pal_we,
  input  logic [MODE_W+1:0]   pal_addr,
  input  logic [3*CW-1:0]     pal_wdata,
  output logic [MODE_W-1:0]   mode_active,
  output logic                out_valid,
  output logic [3*CW-1:0]     rgb
);

  localparam int PAL_N = 4 * NUM_MODES;
  localparam int AW    = MODE_W + 2;
  localparam int CXW   = $clog2(TILE_W);
  localparam int CYW   = $clog2(TILE_H);
  localparam logic [CXW-1:0] c_half_tile = CXW'(TILE_W / 2);

  function automatic logic [3*CW-1:0] scale_default(input logic [29:0] c10);
    logic [3*CW-1:0] r;
    logic [63:0]     ch;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      ch = 64'(c10[k*10 +: 10]);
      r[k*CW +: CW] = CW'((ch << CW) >> 10);
    end
    return r;
  endfunction

  logic [MODE_W-1:0] r_mode_active;
  logic [MODE_W-1:0] w_mode_sel;
  logic              w_wr_ok;
  logic [CXW-1:0]    w_col_cnt;
  logic [CYW-1:0]    w_row_cnt;
  logic              w_col_par;
  logic              w_row_par;
  pix_class_t        w_cls;
  logic              r_s1_valid;
  pix_class_t        r_s1_cls;
  logic [AW-1:0]     r_s1_idx;
  logic [3*CW-1:0]   r_pal [PAL_N];
  logic [3*CW-1:0]   w_pal_rd;
  logic [3*CW-1:0]   w_color;
  logic              r_out_valid;
  logic [3*CW-1:0]   r_rgb;
  logic              w_unused;

  generate
    if (NUM_MODES == (1 << MODE_W)) begin : g_mode_full
      assign w_mode_sel = mode;
      assign w_wr_ok    = 1'b1;
    end else begin : g_mode_partial
      assign w_mode_sel = (32'(mode) < NUM_MODES) ? mode : '0;
      assign w_wr_ok    = (32'(pal_addr[AW-1:2]) < NUM_MODES);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_mode_active <= '0;
    else if (frame_start) r_mode_active <= w_mode_sel;
  end

  field_tile_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_tiles (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .col_cnt     (w_col_cnt),
    .row_cnt     (w_row_cnt),
    .col_par     (w_col_par),
    .row_par     (w_row_par)
  );

  always_comb begin
    w_cls = CLS_BG_A;
    if (px_fg) begin
      w_cls = CLS_FG;
    end else begin
      case (int'(r_mode_active))
        1: w_cls = w_col_par ? CLS_BG_B : CLS_BG_A;
        2: w_cls = ((w_row_cnt == '0) || (w_col_cnt == (w_row_par ? c_half_tile : '0)))
                   ? CLS_LINE : CLS_BG_A;
        3: w_cls = (w_col_par ^ w_row_par) ? CLS_BG_B : CLS_BG_A;
        default: w_cls = CLS_BG_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cls   <= CLS_BG_A;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= pix_valid;
      r_s1_cls   <= w_cls;
      r_s1_idx   <= {r_mode_active, w_cls};
    end
  end

  // A write and a stage-2 read of the same entry in one cycle yields the old colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++)
        r_pal[i] <= scale_default(pal_default10(i / 4, 2'(i % 4)));
    end else if (pal_we && w_wr_ok) begin
      r_pal[pal_addr] <= pal_wdata;
    end
  end

  assign w_pal_rd = r_pal[r_s1_idx];

`ifdef FIELD_FADE_EN
  logic [3:0] r_fade;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fade <= 4'd0;
    end else if (frame_start) begin
      if (w_mode_sel != r_mode_active) r_fade <= 4'd0;
      else if (r_fade != 4'hF)         r_fade <= r_fade + 4'd1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_fade_ch
    logic [CW+3:0] w_prod;
    assign w_prod = {4'd0, w_pal_rd[k*CW +: CW]} * {{CW{1'b0}}, r_fade};
    assign w_color[k*CW +: CW] = (r_s1_cls == CLS_FG) ? w_pal_rd[k*CW +: CW] : w_prod[CW+3:4];
  end
`else
  assign w_color = w_pal_rd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_rgb       <= r_s1_valid ? w_color : '0;
    end
  end

  assign mode_active = r_mode_active;
  assign out_valid   = r_out_valid;
  assign rgb         = r_rgb;
  assign w_unused    = ^{x, y, r_s1_cls};

endmodule

`default_nettype wire

// File: tb/tb_field_color_pipe.sv
// +--------------------------------------------------------------------------+
// | tb_field_color_pipe : randomized bench with a tile-arithmetic model.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_field_color_pipe;
  import field_color_pkg::*;

  localparam int TW = 80;
  localparam int TH = 60;
  localparam int NM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid, line_start, frame_start, px_fg, pal_we;
  logic [9:0]  x, y;
  logic [1:0]  mode;
  logic [3:0]  pal_addr;
  logic [29:0] pal_wdata;
  logic [1:0]  mode_active;
  logic        out_valid;
  logic [29:0] rgb;

  field_color_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .x           (x),
    .y           (y),
    .px_fg       (px_fg),
    .mode        (mode),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .mode_active (mode_active),
    .out_valid   (out_valid),
    .rgb         (rgb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: pixel index in line and line index in frame; tiles from division.
  int          p, ln, m_mode, s1_idx;
  bit          s1_v, e_valid;
  logic [29:0] e_rgb;
  logic [29:0] m_pal [16];
  int          wr_at = -1;
  logic [3:0]  wr_addr;
  logic [29:0] wr_data;
  int          rnd_we_permille = 0;

  function automatic int classify(bit fg, int md, int col, int line);
    int row, tc, tr;
    row = (line < 0) ? 0 : line;
    tc  = col / TW;
    tr  = row / TH;
    if (fg) return 3;
    case (md)
      1:       return tc % 2;
      2:       return ((row % TH == 0) || (col % TW == ((tr % 2 != 0) ? TW / 2 : 0))) ? 2 : 0;
      3:       return (tc + tr) % 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    p = 0; ln = -1; m_mode = 0; s1_v = 0; s1_idx = 0; e_valid = 0; e_rgb = '0;
    for (int i = 0; i < 16; i++) m_pal[i] = pal_default10(i / 4, 2'(i % 4));
  endtask

  task automatic model_edge(input bit fs, input bit ls, input bit pv, input bit fg,
                            input bit we, input logic [3:0] wa, input logic [29:0] wd);
    e_valid = s1_v;
    e_rgb   = s1_v ? m_pal[s1_idx] : 30'h0;
    if (we) m_pal[wa] = wd;
    s1_v   = pv;
    s1_idx = m_mode * 4 + classify(fg, m_mode, p, ln);
    if (fs) begin
      m_mode = (int'(mode) < NM) ? int'(mode) : 0;
      p = 0; ln = -1;
    end else if (ls) begin
      p = 0; ln++;
    end else if (pv) begin
      p++;
    end
  endtask

  task automatic tick(input bit fs, input bit ls, input bit pv, input bit fg,
                      input bit we, input logic [3:0] wa, input logic [29:0] wd);
    frame_start = fs; line_start = ls; pix_valid = pv; px_fg = fg;
    pal_we = we; pal_addr = wa; pal_wdata = wd;
    x = 10'(p); y = 10'((ln < 0) ? 0 : ln);
    @(posedge clk);
    model_edge(fs, ls, pv, fg, we, wa, wd);
    #1;
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("rgb", 64'(rgb), 64'(e_rgb));
    check("mode_active", 64'(mode_active), 64'(m_mode));
  endtask

  task automatic do_line(input int npix, input int gap_pct, input int fg_pct);
    bit          we, fg;
    logic [3:0]  wa;
    logic [29:0] wd;
    tick(0, 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < npix; ) begin
      if (i == wr_at) begin
        we = 1; wa = wr_addr; wd = wr_data; wr_at = -1;
      end else begin
        we = ($urandom_range(999) < rnd_we_permille);
        wa = 4'($urandom_range(15));
        wd = 30'($urandom);
      end
      fg = ($urandom_range(99) < fg_pct);
      if ($urandom_range(99) < gap_pct) begin
        tick(0, 0, 0, fg, we, wa, wd);
      end else begin
        tick(0, 0, 1, fg, we, wa, wd);
        i++;
      end
    end
    repeat (3) tick(0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic frame(input logic [1:0] md, input int nlines, input int npix,
                       input int gap_pct, input int fg_pct, input int mid_mode);
    mode = md;
    tick(1, 0, 0, 0, 0, '0, '0);
    tick(0, 0, 0, 0, 0, '0, '0);
    for (int l = 0; l < nlines; l++) begin
      if (mid_mode >= 0 && l == nlines / 2) mode = 2'(mid_mode);
      else if (mid_mode < 0 && l > 0) mode = 2'($urandom_range(3));
      do_line(npix, gap_pct, fg_pct);
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 0; line_start = 0; frame_start = 0; px_fg = 0; pal_we = 0;
    x = '0; y = '0; mode = '0; pal_addr = '0; pal_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_rgb", 64'(rgb), 64'(0));
    check("reset_mode_active", 64'(mode_active), 64'(0));
    rst = 1'b0;

    frame(2'd0, 1, 640, 0, 0, -1);     // solid court
    frame(2'd1, 3, 200, 10, 0, 3);     // stripes, mid-frame request for checker
    frame(2'd3, 70, 170, 5, 10, -1);   // checker across a row-tile boundary
    frame(2'd2, 125, 130, 5, 5, -1);   // bricks across two row tiles

    wr_at = 100; wr_addr = 4'h0; wr_data = 30'h3FF00000;
    frame(2'd0, 2, 200, 0, 0, -1);

    rnd_we_permille = 20;
    for (int f = 0; f < 4; f++) frame(2'($urandom_range(3)), 10, 200, 15, 20, -1);

    mode = 2'd2;
    tick(1, 0, 0, 0, 0, '0, '0);
    do_line(130, 5, 5);
    do_line(60, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_rgb", 64'(rgb), 64'(0));
    check("midrst_mode_active", 64'(mode_active), 64'(0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    rnd_we_permille = 0;
    do_line(100, 5, 5);
    frame(2'd1, 2, 200, 5, 5, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
